// File: rtl/demux_pkg.sv
// Shared constants for the 1-to-4 registered demultiplexer.
package demux_pkg;

  localparam int unsigned NUM_OUT = 4;
  localparam int unsigned SEL_W   = 2;

  localparam logic [SEL_W-1:0] SEL_Y0 = 2'd0;
  localparam logic [SEL_W-1:0] SEL_Y1 = 2'd1;
  localparam logic [SEL_W-1:0] SEL_Y2 = 2'd2;
  localparam logic [SEL_W-1:0] SEL_Y3 = 2'd3;

  // Default hit-counter width when DEMUX_CNT_EN is defined.
  localparam int unsigned CNT_W_DEFAULT = 8;

endpackage

// File: rtl/demux_decode.sv
// Combinational 2-to-4 one-hot decoder, gated by in_valid.
module demux_decode
  import demux_pkg::*;
(
  input  logic [SEL_W-1:0]   sel,
  input  logic               in_valid,
  output logic [NUM_OUT-1:0] onehot
);

  // Decode the select into a one-hot route; no route when the input is not valid.
  always_comb begin
    onehot = '0;
    if (in_valid) begin
      unique case (sel)
        SEL_Y0: onehot = 4'b0001;
        SEL_Y1: onehot = 4'b0010;
        SEL_Y2: onehot = 4'b0100;
        SEL_Y3: onehot = 4'b1000;
        default: onehot = '0;
      endcase
    end
  end

endmodule

// File: rtl/demux.sv
// Registered 1-to-4 demultiplexer with one-hot output-valid flags.
// Optional per-output saturating hit counters are built when the macro
// DEMUX_CNT_EN is defined; without it the routing path is unchanged.
module demux
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   D,
  input  logic               s0,
  input  logic               s1,
  input  logic               in_valid,
  output logic [WIDTH-1:0]   y0,
  output logic [WIDTH-1:0]   y1,
  output logic [WIDTH-1:0]   y2,
  output logic [WIDTH-1:0]   y3,
  output logic [NUM_OUT-1:0] y_valid
`ifdef DEMUX_CNT_EN
  ,
  input  logic               cnt_clr,
  output logic [CNT_W-1:0]   cnt0,
  output logic [CNT_W-1:0]   cnt1,
  output logic [CNT_W-1:0]   cnt2,
  output logic [CNT_W-1:0]   cnt3
`endif
);

  logic [NUM_OUT-1:0] hit;
  logic [WIDTH-1:0]   y_d [NUM_OUT];
  logic [WIDTH-1:0]   y_q [NUM_OUT];
  logic [NUM_OUT-1:0] y_valid_q;

  demux_decode u_decode (
    .sel      ({s1, s0}),
    .in_valid (in_valid),
    .onehot   (hit)
  );

  // Non-selected outputs are forced to zero so nothing holds over between routes.
  always_comb begin
    for (int i = 0; i < NUM_OUT; i++) begin
      y_d[i] = hit[i] ? D : '0;
    end
  end

  // Output register: one cycle of latency, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_OUT; i++) begin
        y_q[i] <= '0;
      end
      y_valid_q <= '0;
    end else begin
      for (int i = 0; i < NUM_OUT; i++) begin
        y_q[i] <= y_d[i];
      end
      y_valid_q <= hit;
    end
  end

  assign y0      = y_q[0];
  assign y1      = y_q[1];
  assign y2      = y_q[2];
  assign y3      = y_q[3];
  assign y_valid = y_valid_q;

`ifdef DEMUX_CNT_EN
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_d [NUM_OUT];
  logic [CNT_W-1:0] cnt_q [NUM_OUT];

  // Saturating hit counters; a clear in the same cycle as a hit wins.
  always_comb begin
    for (int i = 0; i < NUM_OUT; i++) begin
      cnt_d[i] = cnt_q[i];
      if (cnt_clr) begin
        cnt_d[i] = '0;
      end else if (hit[i] && (cnt_q[i] != CntMax)) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Counter state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_OUT; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_OUT; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign cnt0 = cnt_q[0];
  assign cnt1 = cnt_q[1];
  assign cnt2 = cnt_q[2];
  assign cnt3 = cnt_q[3];
`endif

endmodule

// File: tb/tb_demux.sv
// Scoreboard bench for demux: the driver pushes expected outputs per sample,
// the monitor pops and compares one cycle later.
module tb_demux;

  localparam int unsigned W  = 4;
  localparam int unsigned CW = 2;
  localparam int unsigned CMAX = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] D = '0;
  logic         s0 = 1'b0;
  logic         s1 = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] y0, y1, y2, y3;
  logic [3:0]   y_valid;
`ifdef DEMUX_CNT_EN
  logic          cnt_clr = 1'b0;
  logic [CW-1:0] cnt0, cnt1, cnt2, cnt3;
`endif

  typedef struct packed {
    logic [3:0]      vld;
    logic [4*W-1:0]  y;
    logic [4*CW-1:0] cnt;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_fail = 0;
  int unsigned mcnt[4];

  demux #(
    .WIDTH (W),
    .CNT_W (CW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .D        (D),
    .s0       (s0),
    .s1       (s1),
    .in_valid (in_valid),
    .y0       (y0),
    .y1       (y1),
    .y2       (y2),
    .y3       (y3),
    .y_valid  (y_valid)
`ifdef DEMUX_CNT_EN
    ,
    .cnt_clr  (cnt_clr),
    .cnt0     (cnt0),
    .cnt1     (cnt1),
    .cnt2     (cnt2),
    .cnt3     (cnt3)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Apply one sample at the falling edge and record what must appear after the next rise.
  task automatic drive(input logic rst, input logic v, input logic [1:0] s,
                       input logic [W-1:0] d, input logic clr);
    exp_t e;
    @(negedge clk);
    rst_n    = rst;
    in_valid = v;
    {s1, s0} = s;
    D        = d;
`ifdef DEMUX_CNT_EN
    cnt_clr  = clr;
`endif
    e = '0;
    if (rst) begin
      if (v) begin
        e.vld[s]       = 1'b1;
        e.y[s*W +: W]  = d;
      end
      for (int i = 0; i < 4; i++) begin
        if (clr) mcnt[i] = 0;
        else if (v && (int'(s) == i) && (mcnt[i] < CMAX)) mcnt[i]++;
      end
    end else begin
      for (int i = 0; i < 4; i++) mcnt[i] = 0;
    end
    for (int i = 0; i < 4; i++) e.cnt[i*CW +: CW] = mcnt[i][CW-1:0];
    sb_q.push_back(e);
  endtask

  // Monitor: compare registered outputs just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      check("y_valid", 64'(y_valid), 64'(mon_e.vld));
      check("y_data", 64'({y3, y2, y1, y0}), 64'(mon_e.y));
`ifdef DEMUX_CNT_EN
      check("cnt", 64'({cnt3, cnt2, cnt1, cnt0}), 64'(mon_e.cnt));
`endif
    end
  end

  initial begin
    for (int i = 0; i < 4; i++) mcnt[i] = 0;
    in_valid = 1'b1;
    D        = 4'h1;

    // Reset held with a valid sample present: outputs stay zero.
    repeat (3) drive(1'b0, 1'b1, 2'd0, 4'h1, 1'b0);

    // Data zero still flags the route.
    for (int s = 0; s < 4; s++) drive(1'b1, 1'b1, 2'(s), 4'h0, 1'b0);
    // Data one swept across every output.
    for (int s = 0; s < 4; s++) drive(1'b1, 1'b1, 2'(s), 4'h1, 1'b0);

    // Route to y2, then drop valid.
    drive(1'b1, 1'b1, 2'd2, 4'h1, 1'b0);
    drive(1'b1, 1'b0, 2'd2, 4'h1, 1'b0);

    // Back-to-back select and data changes.
    drive(1'b1, 1'b1, 2'd3, 4'hA, 1'b0);
    drive(1'b1, 1'b1, 2'd0, 4'h5, 1'b0);
    drive(1'b1, 1'b1, 2'd3, 4'h0, 1'b0);
    drive(1'b1, 1'b1, 2'd1, 4'hF, 1'b0);

    // Clear the model and DUT counters, then saturate output 1.
    drive(1'b1, 1'b0, 2'd0, 4'h0, 1'b1);
    repeat (5) drive(1'b1, 1'b1, 2'd1, 4'h3, 1'b0);
    drive(1'b1, 1'b1, 2'd1, 4'h3, 1'b1);
    drive(1'b1, 1'b1, 2'd2, 4'h7, 1'b0);

    // Asynchronous reset pulse between edges.
    drive(1'b1, 1'b1, 2'd3, 4'hF, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_y", 64'({y3, y2, y1, y0}), 64'(0));
    check("async_rst_vld", 64'(y_valid), 64'(0));
`ifdef DEMUX_CNT_EN
    check("async_rst_cnt", 64'({cnt3, cnt2, cnt1, cnt0}), 64'(0));
`endif
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) mcnt[i] = 0;

    // First samples after release.
    drive(1'b1, 1'b1, 2'd0, 4'h6, 1'b0);
    drive(1'b1, 1'b1, 2'd2, 4'h9, 1'b0);
    drive(1'b1, 1'b0, 2'd0, 4'h0, 1'b0);

    // Drain the scoreboard within a bounded number of cycles.
    for (int k = 0; k < 6; k++) begin
      if (sb_q.size() == 0) break;
      @(posedge clk);
      #2;
    end
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
